train_seq_ctrl: RTL and testbench

- Training-sequence controller for the delta weight/bias accumulator datapath.
- Per training sample: accepts the sample, runs forward pass, runs backprop, then pulses the accumulator enable once.
- After BATCH samples: issues one weight-update pulse and clears the accumulators.
- Repeats for a programmed number of epochs, then reports done.

---
 rtl/train_seq_ctrl_pkg.sv | 37 +++
 rtl/train_seq_ctrl_cnt.sv | 34 +++
 rtl/train_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_train_seq_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/train_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : train_seq_ctrl_pkg
// Description : Shared state encoding and default sizing for the training
//               sequence controller.
// Revision    : 1.0 - initial release
// ============================================================================
package train_seq_ctrl_pkg;

    // Default sizing
    localparam int c_batch_dflt   = 4;
    localparam int c_cnt_w_dflt   = 8;
    localparam int c_epoch_w_dflt = 16;

    // State encoding
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_clr      = 3'd1;
    localparam logic [2:0] c_st_wait_smp = 3'd2;
    localparam logic [2:0] c_st_fwd      = 3'd3;
    localparam logic [2:0] c_st_bwd      = 3'd4;
    localparam logic [2:0] c_st_acc      = 3'd5;
    localparam logic [2:0] c_st_upd      = 3'd6;
    localparam logic [2:0] c_st_done     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = c_st_idle,
        ST_CLR      = c_st_clr,
        ST_WAIT_SMP = c_st_wait_smp,
        ST_FWD      = c_st_fwd,
        ST_BWD      = c_st_bwd,
        ST_ACC      = c_st_acc,
        ST_UPD      = c_st_upd,
        ST_DONE     = c_st_done
    } state_t;

endpackage : train_seq_ctrl_pkg
`default_nettype wire

// File: rtl/train_seq_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_cnt
// Description : Up-counter with synchronous clear (priority) and increment
//               enable. Used for the sample and epoch counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count register: clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : ctrl_cnt
`default_nettype wire

// File: rtl/train_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : train_seq_ctrl
// Description : Sequences forward pass, backprop and accumulation per
//               sample, a weight update per mini-batch, over N epochs.
// Revision    : 1.0 - initial release
// ============================================================================
module train_seq_ctrl
    import train_seq_ctrl_pkg::*;
#(
    parameter int BATCH   = c_batch_dflt,
    parameter int CNT_W   = c_cnt_w_dflt,
    parameter int EPOCH_W = c_epoch_w_dflt
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [EPOCH_W-1:0] i_n_epoch,
    input  logic               i_smp_valid,
    output logic               o_smp_ready,
    output logic               o_fwd_start,
    input  logic               i_fwd_done,
    output logic               o_bwd_start,
    input  logic               i_bwd_done,
    output logic               o_acc_en,
    output logic               o_acc_clr,
    output logic               o_upd,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_smp_cnt,
    output logic [EPOCH_W-1:0] o_epoch_cnt
);

    localparam logic [CNT_W-1:0]   c_last_smp = CNT_W'(BATCH - 1);
    localparam logic [EPOCH_W-1:0] c_one_ep   = EPOCH_W'(1);

    state_t             r_state;
    state_t             w_nxt;
    logic [EPOCH_W-1:0] r_n_epoch;

    logic               r_smp_ready;
    logic               r_fwd_start;
    logic               r_bwd_start;
    logic               r_acc_en;
    logic               r_acc_clr;
    logic               r_upd;
    logic               r_busy;
    logic               r_done;

    logic               w_abort;
    logic               w_start_acc;
    logic [CNT_W-1:0]   w_smp_cnt;
    logic [EPOCH_W-1:0] w_epoch_cnt;

    // Abort only matters once a run is in progress; in IDLE it just blocks a start
    assign w_abort     = (r_state != ST_IDLE) && i_abort;
    assign w_start_acc = (r_state == ST_IDLE) && i_start && !i_abort;

    // Next-state decode
    always_comb begin
        w_nxt = r_state;
        if (w_abort) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_acc) begin
                        w_nxt = (i_n_epoch != '0) ? ST_CLR : ST_DONE;
                    end
                end
                ST_CLR:      w_nxt = ST_WAIT_SMP;
                ST_WAIT_SMP: begin
                    if (i_smp_valid && r_smp_ready) begin
                        w_nxt = ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (i_fwd_done) begin
                        w_nxt = ST_BWD;
                    end
                end
                ST_BWD: begin
                    if (i_bwd_done) begin
                        w_nxt = ST_ACC;
                    end
                end
                ST_ACC:  w_nxt = (w_smp_cnt == c_last_smp) ? ST_UPD : ST_WAIT_SMP;
                ST_UPD:  w_nxt = (w_epoch_cnt == (r_n_epoch - c_one_ep)) ? ST_DONE : ST_CLR;
                ST_DONE: w_nxt = ST_IDLE;
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Latch the epoch target on an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n_epoch <= '0;
        end else if (w_start_acc) begin
            r_n_epoch <= i_n_epoch;
        end
    end

    // Registered outputs decoded from the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp_ready <= 1'b0;
            r_fwd_start <= 1'b0;
            r_bwd_start <= 1'b0;
            r_acc_en    <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_upd       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_smp_ready <= (w_nxt == ST_WAIT_SMP);
            r_fwd_start <= (w_nxt == ST_FWD) && (r_state != ST_FWD);
            r_bwd_start <= (w_nxt == ST_BWD) && (r_state != ST_BWD);
            r_acc_en    <= (w_nxt == ST_ACC);
            r_acc_clr   <= (w_nxt == ST_CLR);
            r_upd       <= (w_nxt == ST_UPD);
            r_busy      <= (w_nxt != ST_IDLE);
            r_done      <= (w_nxt == ST_DONE);
        end
    end

    ctrl_cnt #(
        .W     (CNT_W)
    ) u_smp_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_abort || w_start_acc || (r_state == ST_CLR)),
        .i_inc (r_state == ST_ACC),
        .o_cnt (w_smp_cnt)
    );

    ctrl_cnt #(
        .W     (EPOCH_W)
    ) u_epoch_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_abort || w_start_acc),
        .i_inc (r_state == ST_UPD),
        .o_cnt (w_epoch_cnt)
    );

    assign o_smp_ready = r_smp_ready;
    assign o_fwd_start = r_fwd_start;
    assign o_bwd_start = r_bwd_start;
    assign o_acc_en    = r_acc_en;
    assign o_acc_clr   = r_acc_clr;
    assign o_upd       = r_upd;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_smp_cnt   = w_smp_cnt;
    assign o_epoch_cnt = w_epoch_cnt;

endmodule : train_seq_ctrl
`default_nettype wire

// File: tb/tb_train_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_train_seq_ctrl
// Description : Directed self-checking bench for train_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_train_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic [15:0] i_n_epoch;
    logic        i_smp_valid;
    logic        o_smp_ready;
    logic        o_fwd_start;
    logic        i_fwd_done;
    logic        o_bwd_start;
    logic        i_bwd_done;
    logic        o_acc_en;
    logic        o_acc_clr;
    logic        o_upd;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_smp_cnt;
    logic [15:0] o_epoch_cnt;

    int checks;
    int passes;

    // pulse counters maintained by tick()
    int n_acc, n_upd, n_clr, n_done, n_fwd, n_bwd, n_excl;

    // automatic done responder: done follows start by one cycle
    logic auto_mode;
    logic fs_d, bs_d;

    train_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_n_epoch   (i_n_epoch),
        .i_smp_valid (i_smp_valid),
        .o_smp_ready (o_smp_ready),
        .o_fwd_start (o_fwd_start),
        .i_fwd_done  (i_fwd_done),
        .o_bwd_start (o_bwd_start),
        .i_bwd_done  (i_bwd_done),
        .o_acc_en    (o_acc_en),
        .o_acc_clr   (o_acc_clr),
        .o_upd       (o_upd),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_smp_cnt   (o_smp_cnt),
        .o_epoch_cnt (o_epoch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_counts();
        n_acc = 0; n_upd = 0; n_clr = 0; n_done = 0;
        n_fwd = 0; n_bwd = 0; n_excl = 0;
    endtask

    // advance one cycle, sample outputs 1ns after the edge, drive responder
    task automatic tick();
        @(posedge clk);
        #1;
        if (o_acc_en)    n_acc++;
        if (o_upd)       n_upd++;
        if (o_acc_clr)   n_clr++;
        if (o_done)      n_done++;
        if (o_fwd_start) n_fwd++;
        if (o_bwd_start) n_bwd++;
        if ($countones({o_acc_en, o_upd, o_acc_clr, o_done}) > 1) n_excl++;
        if (auto_mode) begin
            i_fwd_done = fs_d;
            i_bwd_done = bs_d;
            fs_d       = o_fwd_start;
            bs_d       = o_bwd_start;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({o_smp_ready, o_fwd_start, o_bwd_start, o_acc_en, o_acc_clr, o_upd, o_busy, o_done} !== 8'h00) begin
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {o_smp_ready, o_fwd_start, o_bwd_start, o_acc_en, o_acc_clr, o_upd, o_busy, o_done});
        end else passes++;
        checks++;
        if (o_smp_cnt !== 8'd0 || o_epoch_cnt !== 16'd0) begin
            $display("FAIL reset_counters: got smp=%0d epoch=%0d expected 0/0", o_smp_cnt, o_epoch_cnt);
        end else passes++;
    endtask

    task automatic test_nominal();
        int n;
        auto_mode = 1'b1; fs_d = 1'b0; bs_d = 1'b0;
        i_fwd_done = 1'b0; i_bwd_done = 1'b0;
        i_smp_valid = 1'b1;
        i_n_epoch = 16'd2;
        clr_counts();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 1;
        checks++;
        if (o_acc_clr !== 1'b1 || o_busy !== 1'b1) begin
            $display("FAIL nom_start_latency: got clr=%b busy=%b expected 1/1", o_acc_clr, o_busy);
        end else passes++;
        while (o_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 53) $display("FAIL nom_done_cycle: got %0d expected 53", n);
        else passes++;
        checks++;
        if (n_acc !== 8 || n_upd !== 2 || n_clr !== 2 || n_done !== 1) begin
            $display("FAIL nom_pulses: got acc=%0d upd=%0d clr=%0d done=%0d expected 8/2/2/1",
                     n_acc, n_upd, n_clr, n_done);
        end else passes++;
        checks++;
        if (o_epoch_cnt !== 16'd2 || o_smp_cnt !== 8'd4) begin
            $display("FAIL nom_counters: got epoch=%0d smp=%0d expected 2/4", o_epoch_cnt, o_smp_cnt);
        end else passes++;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            $display("FAIL nom_idle: got busy=%b done=%b expected 0/0", o_busy, o_done);
        end else passes++;
        checks++;
        if (n_excl !== 0) $display("FAIL nom_exclusive: got %0d overlaps expected 0", n_excl);
        else passes++;
    endtask

    task automatic test_zero_epochs();
        clr_counts();
        i_n_epoch = 16'd0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_done !== 1'b1) $display("FAIL zero_done: got %b expected 1", o_done);
        else passes++;
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            $display("FAIL zero_idle: got done=%b busy=%b expected 0/0", o_done, o_busy);
        end else passes++;
        checks++;
        if (n_clr !== 0 || n_acc !== 0 || n_upd !== 0) begin
            $display("FAIL zero_pulses: got clr=%0d acc=%0d upd=%0d expected 0/0/0", n_clr, n_acc, n_upd);
        end else passes++;
    endtask

    task automatic test_stall();
        int bad;
        i_smp_valid = 1'b0;
        i_n_epoch = 16'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        clr_counts();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_smp_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0 || n_fwd !== 0) begin
            $display("FAIL stall_hold: got not_ready=%0d fwd=%0d expected 0/0", bad, n_fwd);
        end else passes++;
        i_smp_valid = 1'b1;
        tick();
        checks++;
        if (o_fwd_start !== 1'b1 || o_smp_ready !== 1'b0) begin
            $display("FAIL stall_release: got fwd=%b ready=%b expected 1/0", o_fwd_start, o_smp_ready);
        end else passes++;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0) $display("FAIL stall_abort: got busy=%b expected 0", o_busy);
        else passes++;
    endtask

    task automatic test_spurious_done();
        int bad;
        int n;
        auto_mode = 1'b0;
        i_fwd_done = 1'b0; i_bwd_done = 1'b0;
        i_smp_valid = 1'b0;
        i_n_epoch = 16'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_fwd_done = 1'b1; i_bwd_done = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_smp_ready !== 1'b1 || o_fwd_start || o_bwd_start || o_acc_en) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL spur_wait_hold: got %0d bad cycles expected 0", bad);
        else passes++;
        clr_counts();
        i_smp_valid = 1'b1;
        n = 0;
        while (o_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n_acc !== 4 || n_fwd !== 4 || n_bwd !== 4 || n_upd !== 1 || n_done !== 1) begin
            $display("FAIL spur_pulses: got acc=%0d fwd=%0d bwd=%0d upd=%0d done=%0d expected 4/4/4/1/1",
                     n_acc, n_fwd, n_bwd, n_upd, n_done);
        end else passes++;
        checks++;
        if (o_epoch_cnt !== 16'd1) $display("FAIL spur_epoch: got %0d expected 1", o_epoch_cnt);
        else passes++;
        i_fwd_done = 1'b0; i_bwd_done = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int n;
        auto_mode = 1'b1; fs_d = 1'b0; bs_d = 1'b0;
        i_smp_valid = 1'b1;
        i_n_epoch = 16'd2;
        clr_counts();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        while (!(o_bwd_start === 1'b1 && o_smp_cnt === 8'd2) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100 || o_epoch_cnt !== 16'd0) begin
            $display("FAIL abort_reach: got cycles=%0d epoch=%0d expected <100/0", n, o_epoch_cnt);
        end else passes++;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_smp_cnt !== 8'd0 || o_epoch_cnt !== 16'd0) begin
            $display("FAIL abort_state: got busy=%b smp=%0d epoch=%0d expected 0/0/0", o_busy, o_smp_cnt, o_epoch_cnt);
        end else passes++;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (n_upd !== 0 || n_done !== 0) begin
            $display("FAIL abort_no_pulse: got upd=%0d done=%0d expected 0/0", n_upd, n_done);
        end else passes++;
        i_n_epoch = 16'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_acc_clr !== 1'b1 || o_busy !== 1'b1) begin
            $display("FAIL abort_restart: got clr=%b busy=%b expected 1/1", o_acc_clr, o_busy);
        end else passes++;
    endtask

    task automatic test_async_reset();
        int n;
        int idle_seen;
        clr_counts();
        idle_seen = 0;
        i_start = 1'b1;
        n = 0;
        while (n_acc < 2 && n < 100) begin
            tick();
            n++;
            if (o_busy !== 1'b1) idle_seen++;
        end
        checks++;
        if (idle_seen !== 0 || n_clr !== 0 || o_smp_cnt !== 8'd1 || o_epoch_cnt !== 16'd0) begin
            $display("FAIL start_ignored: got idle=%0d clr=%0d smp=%0d epoch=%0d expected 0/0/1/0",
                     idle_seen, n_clr, o_smp_cnt, o_epoch_cnt);
        end else passes++;
        i_start = 1'b0;
        n = 0;
        while (o_fwd_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({o_smp_ready, o_fwd_start, o_bwd_start, o_acc_en, o_acc_clr, o_upd, o_busy, o_done} !== 8'h00
            || o_smp_cnt !== 8'd0 || o_epoch_cnt !== 16'd0 || n >= 20) begin
            $display("FAIL async_reset: got out=%b smp=%0d epoch=%0d wait=%0d expected 0/0/0/<20",
                     {o_smp_ready, o_fwd_start, o_bwd_start, o_acc_en, o_acc_clr, o_upd, o_busy, o_done},
                     o_smp_cnt, o_epoch_cnt, n);
        end else passes++;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_acc_clr !== 1'b0) begin
            $display("FAIL post_reset_idle: got busy=%b clr=%b expected 0/0", o_busy, o_acc_clr);
        end else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_n_epoch = 16'd0;
        i_smp_valid = 1'b0;
        i_fwd_done = 1'b0;
        i_bwd_done = 1'b0;
        auto_mode = 1'b0;
        fs_d = 1'b0;
        bs_d = 1'b0;
        clr_counts();
        tick();
        tick();
        test_reset();
        rst = 1'b1;
        tick();
        test_nominal();
        test_zero_epochs();
        test_stall();
        test_spurious_done();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_train_seq_ctrl
`default_nettype wire
